// File: rtl/cmp_feeder.sv
// Operand sequencer for cmp_unit: joins weight/pixel streams, issues klen MACs per window,
// waits out the cmp_unit pipeline and hands the captured partial sum downstream.
module cmp_feeder #(
  parameter int DATA_W  = 16,
  parameter int PSUM_W  = 32,
  parameter int KLEN_W  = 8,
  parameter int CMP_LAT = 2
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              start,
  input  logic [KLEN_W-1:0] cfg_klen,
  output logic              busy,
  output logic              done,
  input  logic              wt_valid,
  output logic              wt_ready,
  input  logic [DATA_W-1:0] wt_data,
  input  logic              px_valid,
  output logic              px_ready,
  input  logic [DATA_W-1:0] px_data,
  output logic [DATA_W-1:0] weight,
  output logic [DATA_W-1:0] pixel,
  output logic              weight_state,
  output logic              ifm_state,
  output logic              psum_clear,
  input  logic [PSUM_W-1:0] psum_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PSUM_W-1:0] out_psum
);

  localparam int DCW = $clog2(CMP_LAT + 1);
  localparam logic [DCW-1:0]    DRAIN_LAST = DCW'(CMP_LAT);
  localparam logic [DCW-1:0]    DRAIN_ONE  = DCW'(1);
  localparam logic [KLEN_W-1:0] KLEN_ONE   = KLEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t            state, state_nxt;
  logic [KLEN_W-1:0] klen;
  logic [KLEN_W-1:0] issue_cnt;
  logic [DCW-1:0]    drain_cnt;
  logic              xfer;

  always_ff @(posedge clock) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    xfer       = 1'b0;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    wt_ready   = 1'b0;
    px_ready   = 1'b0;
    psum_clear = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        psum_clear = 1'b1;
        state_nxt  = (klen == '0) ? S_OUT : S_ISSUE;
      end
      S_ISSUE: begin
        // Both streams are consumed together or not at all.
        xfer     = wt_valid & px_valid;
        wt_ready = xfer;
        px_ready = xfer;
        if (xfer && (issue_cnt == klen - KLEN_ONE)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_nxt = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      klen         <= '0;
      issue_cnt    <= '0;
      drain_cnt    <= '0;
      weight       <= '0;
      pixel        <= '0;
      weight_state <= 1'b0;
      ifm_state    <= 1'b0;
      out_valid    <= 1'b0;
      out_psum     <= '0;
    end else begin
      // Any cycle without a transfer presents a zero bubble to cmp_unit.
      weight       <= xfer ? wt_data : '0;
      pixel        <= xfer ? px_data : '0;
      weight_state <= xfer && (wt_data != '0);
      ifm_state    <= xfer && (px_data != '0);
      case (state)
        S_IDLE: begin
          issue_cnt <= '0;
          drain_cnt <= '0;
          if (start) klen <= cfg_klen;
        end
        S_LOAD: begin
          issue_cnt <= '0;
          drain_cnt <= '0;
          if (klen == '0) begin
            out_psum  <= '0;
            out_valid <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (xfer) issue_cnt <= issue_cnt + KLEN_ONE;
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            out_psum  <= psum_in;
            out_valid <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_ONE;
          end
        end
        S_OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
